ex_muldiv_unit: RTL and testbench
=================================

# ex_muldiv_unit

Iterative multiply/divide unit with architectural HI/LO registers, parametrised in operand width. It sits beside the EX-stage ALU and replaces fixed HI/LO inputs with a sequential unit that computes MULT/MULTU/DIV/DIVU over multiple cycles. It drives a busy/stall indication to the pipeline control, and it supports MTHI/MTLO writes and flush-abort.

## Interface
- WIDTH, 32, operand and HI/LO width; legal values are 4 or greater.
- clk_in  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only while the unit is idle.
- op  input  3  operation select:
  - 000 MULTU, 001 MULT, 010 DIVU, 011 DIV.
  - 100 MTHI, 101 MTLO.
  - 110 and 111 are no-ops.
- a  input  WIDTH  multiplicand / dividend / MTHI/MTLO source.
- b  input  WIDTH  multiplier / divisor.
- flush  input  1  abort any in-flight operation.
- busy  output  1  high while an operation is in flight; EX stalls on any HI/LO consumer while high.
- done  output  1  single-cycle pulse; HI/LO hold the new result.
- hi  output  WIDTH  HI register (product upper half / remainder).
- lo  output  WIDTH  LO register (product lower half / quotient).

## Operation
- States are IDLE, CALC and FIX.
- IDLE:
  - start with op 000–011 latches the operands and goes to CALC with iteration counter = 0.
  - For signed ops (001, 011), the magnitudes |a| and |b| are latched, plus the result sign flags.
  - Product sign = a[MSB]^b[MSB]. Quotient sign = a[MSB]^b[MSB]. Remainder sign = a[MSB].
- MTHI/MTLO in IDLE with start: hi (or lo) <= a at that edge. The unit stays IDLE, busy stays low, and there is no done pulse.
- CALC multiply: shift-add over a 2*WIDTH accumulator, one multiplier bit per cycle.
- CALC divide: restoring division, one quotient bit per cycle.
- CALC runs for exactly WIDTH cycles, with the counter going 0..WIDTH-1. It leaves CALC at counter = WIDTH-1.
- FIX, one cycle:
  - Applies two's-complement negation per the sign flags for signed ops.
  - Writes hi/lo, pulses done, and returns to IDLE.
- Width rules:
  - Multiply result is 2*WIDTH bits: hi = upper WIDTH bits, lo = lower WIDTH bits.
  - Divide: lo = quotient and hi = remainder, each WIDTH bits, truncating toward zero.
- Divide by zero (b == 0), all ops, fixed latency preserved: lo = all ones, hi = a (raw input value, no sign fix).
- Signed overflow, DIV with a = most-negative and b = -1: lo = most-negative, hi = 0. No flag is raised.
- start while busy is ignored, and so is start with op 110/111.
- flush:
  - In CALC or FIX it returns to IDLE on the next edge.
  - hi/lo keep their pre-operation values and no done pulse occurs.
  - flush has priority over the FIX write.
  - flush in IDLE has priority over start: the request is dropped.
- hi/lo change only on a FIX write or an MTHI/MTLO write.

## Timing
- Reset (asynchronous): state = IDLE, counter = 0, busy = 0, done = 0, hi = 0, lo = 0, operand/accumulator registers = 0.
- Reset mid-operation aborts immediately, with the same values as above.
- Start accepted at edge E0. busy is high from after E0 until after the FIX edge.
- CALC edges are E1..E_WIDTH. The FIX edge is E_(WIDTH+1).
- After E_(WIDTH+1): hi/lo hold the result, done = 1 for one cycle, and busy = 0.
- Total latency is WIDTH+1 cycles from the accepting edge to result visible (33 for WIDTH = 32), independent of operand values.
- Back-to-back: a new start may be accepted at the edge at which done is high. The next result then appears WIDTH+1 cycles later.
- MTHI/MTLO: zero-wait; the value is visible the cycle after the accepting edge.
- busy is a registered output; done is registered. There are no combinational paths from inputs to outputs.

## Test plan
- Reset, then MULTU WIDTH = 32, a = 0xFFFFFFFF, b = 0xFFFFFFFF -> done exactly 33 cycles after acceptance, hi = 0xFFFFFFFE, lo = 0x00000001; busy high for 33 cycles.
- MULT a = -7 (0xFFFFFFF9), b = 3 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFEB; then DIV a = -7, b = 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
- DIVU a = 100, b = 0 -> after 33 cycles lo = 0xFFFFFFFF, hi = 100. DIV a = 0x80000000, b = 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
- Start DIVU a = 10, b = 3, with a second start (MULTU) asserted during busy -> ignored, single done with lo = 3, hi = 1. Then issue start at the done cycle and check the chained result.
- MTHI a = 0x1234 -> hi = 0x1234 next cycle, busy stays 0, no done. Then start MULTU and assert flush at CALC cycle 10 -> busy drops next edge, no done, hi = 0x1234 unchanged.
- WIDTH = 8 instance: MULT a = 0x80, b = 0x80 -> hi = 0x40, lo = 0x00, latency 9. Assert rst mid-CALC -> all outputs 0 immediately.

Source files
------------

// File: rtl/ex_muldiv_unit_if.sv
// Request/result bundle between the EX-stage pipeline control and the multiply/divide unit.
interface ex_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers: one bit per cycle over WIDTH cycles,
// then a single sign-fix cycle that writes HI/LO and pulses done.
module ex_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk_in,
    input  logic               rst,
    ex_muldiv_unit_if.slave    bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   a_raw_q, a_raw_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;
    logic               rem_neg_q, rem_neg_d;
    logic               div0_q, div0_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               sgn_op;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_trial, div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign sgn_op = bus.op[0];
    assign a_mag  = (sgn_op && bus.a[WIDTH-1]) ? (~bus.a + 1'b1) : bus.a;
    assign b_mag  = (sgn_op && bus.b[WIDTH-1]) ? (~bus.b + 1'b1) : bus.b;

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each cycle.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide: acc = {partial remainder, dividend/quotient bits}, shifted left each cycle.
    assign div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_ge    = (div_trial >= {1'b0, opnd_q});
    assign div_diff  = div_trial - {1'b0, opnd_q};
    assign div_next  = {(div_ge ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};

    assign prod_fix = neg_q ? (~acc_q + 1'b1) : acc_q;
    assign quo_fix  = neg_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    assign rem_fix  = rem_neg_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        a_raw_d   = a_raw_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        div0_d    = div0_q;
        done_d    = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            S_IDLE: begin
                // flush in IDLE drops any request, including MTHI/MTLO
                if (bus.start && !bus.flush) begin
                    if (!bus.op[2]) begin
                        state_d   = S_CALC;
                        cnt_d     = '0;
                        is_div_d  = bus.op[1];
                        neg_d     = sgn_op & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        rem_neg_d = sgn_op & bus.a[WIDTH-1];
                        div0_d    = (bus.b == '0);
                        a_raw_d   = bus.a;
                        if (bus.op[1]) begin
                            acc_d  = {{WIDTH{1'b0}}, a_mag};
                            opnd_d = b_mag;
                        end else begin
                            acc_d  = {{WIDTH{1'b0}}, b_mag};
                            opnd_d = a_mag;
                        end
                    end else if (!bus.op[1]) begin
                        if (bus.op[0]) lo_d = bus.a;
                        else           hi_d = bus.a;
                    end
                end
            end
            S_CALC: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    acc_d = is_div_q ? div_next : mul_next;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH-1)) begin
                        state_d = S_FIX;
                        cnt_d   = '0;
                    end
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!bus.flush) begin
                    done_d = 1'b1;
                    if (!is_div_q) begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end else if (div0_q) begin
                        hi_d = a_raw_q;
                        lo_d = '1;
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            a_raw_q   <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            div0_q    <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            a_raw_q   <= a_raw_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            div0_q    <= div0_d;
            done_q    <= done_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign bus.busy = (state_q != S_IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: a 32-bit and an 8-bit instance share clock and reset.
module tb_ex_muldiv_unit;
    logic clk_in = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   lat;
    int   busy_cnt;
    int   done_cnt;

    always #5 clk_in = ~clk_in;

    ex_muldiv_unit_if #(.WIDTH(32)) bus32 ();
    ex_muldiv_unit_if #(.WIDTH(8))  bus8 ();

    ex_muldiv_unit #(.WIDTH(32)) u_dut32 (.clk_in(clk_in), .rst(rst), .bus(bus32));
    ex_muldiv_unit #(.WIDTH(8))  u_dut8  (.clk_in(clk_in), .rst(rst), .bus(bus8));

    // Advance one rising edge, then settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic sel_busy(input bit w8);
        return w8 ? bus8.busy : bus32.busy;
    endfunction

    function automatic logic sel_done(input bit w8);
        return w8 ? bus8.done : bus32.done;
    endfunction

    // Hold start for exactly one edge, then release it.
    task automatic apply_stimulus(input bit w8, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (w8) begin
            bus8.op = op; bus8.a = a[7:0]; bus8.b = b[7:0]; bus8.start = 1'b1;
        end else begin
            bus32.op = op; bus32.a = a; bus32.b = b; bus32.start = 1'b1;
        end
        tick();
        bus8.start  = 1'b0;
        bus32.start = 1'b0;
    endtask

    // Counts edges until done appears (bounded), and how many samples showed busy on the way.
    task automatic wait_done(input bit w8, output int n, output int nbusy);
        n = 0;
        nbusy = 0;
        while (!sel_done(w8) && n < 60) begin
            if (sel_busy(w8)) nbusy++;
            tick();
            n++;
        end
    endtask

    initial begin
        rst = 1'b1;
        bus32.start = 1'b0; bus32.op = 3'd0; bus32.a = '0; bus32.b = '0; bus32.flush = 1'b0;
        bus8.start  = 1'b0; bus8.op  = 3'd0; bus8.a  = '0; bus8.b  = '0; bus8.flush  = 1'b0;
        #12;
        check_output("rst_busy", 64'(bus32.busy), 64'd0);
        check_output("rst_done", 64'(bus32.done), 64'd0);
        check_output("rst_hi",   64'(bus32.hi),   64'd0);
        check_output("rst_lo",   64'(bus32.lo),   64'd0);
        rst = 1'b0;
        tick();

        $display("[TB] MULTU max*max");
        apply_stimulus(1'b0, 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(1'b0, lat, busy_cnt);
        check_output("multu_lat",  64'(lat), 64'd33);
        check_output("multu_busy", 64'(busy_cnt), 64'd33);
        check_output("multu_busy_at_done", 64'(bus32.busy), 64'd0);
        check_output("multu_hi", 64'(bus32.hi), 64'hFFFF_FFFE);
        check_output("multu_lo", 64'(bus32.lo), 64'h0000_0001);
        tick();
        check_output("multu_done_pulse", 64'(bus32.done), 64'd0);

        $display("[TB] MULT -7*3 and DIV -7/2");
        apply_stimulus(1'b0, 3'b001, 32'hFFFF_FFF9, 32'd3);
        wait_done(1'b0, lat, busy_cnt);
        check_output("mult_lat", 64'(lat), 64'd33);
        check_output("mult_hi", 64'(bus32.hi), 64'hFFFF_FFFF);
        check_output("mult_lo", 64'(bus32.lo), 64'hFFFF_FFEB);
        tick();
        apply_stimulus(1'b0, 3'b011, 32'hFFFF_FFF9, 32'd2);
        wait_done(1'b0, lat, busy_cnt);
        check_output("div_lat", 64'(lat), 64'd33);
        check_output("div_lo", 64'(bus32.lo), 64'hFFFF_FFFD);
        check_output("div_hi", 64'(bus32.hi), 64'hFFFF_FFFF);
        tick();

        $display("[TB] divide by zero and signed overflow");
        apply_stimulus(1'b0, 3'b010, 32'd100, 32'd0);
        wait_done(1'b0, lat, busy_cnt);
        check_output("div0_lat", 64'(lat), 64'd33);
        check_output("div0_lo", 64'(bus32.lo), 64'hFFFF_FFFF);
        check_output("div0_hi", 64'(bus32.hi), 64'd100);
        tick();
        apply_stimulus(1'b0, 3'b011, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(1'b0, lat, busy_cnt);
        check_output("ovf_lo", 64'(bus32.lo), 64'h8000_0000);
        check_output("ovf_hi", 64'(bus32.hi), 64'd0);
        tick();

        $display("[TB] start while busy ignored, then chained start on done");
        apply_stimulus(1'b0, 3'b010, 32'd10, 32'd3);
        for (int i = 0; i < 4; i++) tick();
        apply_stimulus(1'b0, 3'b000, 32'd5, 32'd7);
        wait_done(1'b0, lat, busy_cnt);
        check_output("divu_lat_after_ignored", 64'(lat), 64'd28);
        check_output("divu_lo", 64'(bus32.lo), 64'd3);
        check_output("divu_hi", 64'(bus32.hi), 64'd1);
        apply_stimulus(1'b0, 3'b000, 32'd6, 32'd7);
        check_output("chain_busy", 64'(bus32.busy), 64'd1);
        check_output("chain_done_dropped", 64'(bus32.done), 64'd0);
        wait_done(1'b0, lat, busy_cnt);
        check_output("chain_lat", 64'(lat), 64'd33);
        check_output("chain_lo", 64'(bus32.lo), 64'd42);
        check_output("chain_hi", 64'(bus32.hi), 64'd0);
        tick();

        $display("[TB] MTHI/MTLO and flush");
        apply_stimulus(1'b0, 3'b100, 32'h0000_1234, 32'd0);
        check_output("mthi_hi", 64'(bus32.hi), 64'h1234);
        check_output("mthi_busy", 64'(bus32.busy), 64'd0);
        check_output("mthi_done", 64'(bus32.done), 64'd0);
        check_output("mthi_lo_kept", 64'(bus32.lo), 64'd42);
        apply_stimulus(1'b0, 3'b101, 32'h0000_5678, 32'd0);
        check_output("mtlo_lo", 64'(bus32.lo), 64'h5678);
        check_output("mtlo_hi_kept", 64'(bus32.hi), 64'h1234);
        apply_stimulus(1'b0, 3'b000, 32'd3, 32'd4);
        for (int i = 0; i < 10; i++) tick();
        check_output("flush_pre_busy", 64'(bus32.busy), 64'd1);
        bus32.flush = 1'b1;
        tick();
        bus32.flush = 1'b0;
        check_output("flush_busy", 64'(bus32.busy), 64'd0);
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus32.done) done_cnt++;
            tick();
        end
        check_output("flush_no_done", 64'(done_cnt), 64'd0);
        check_output("flush_hi", 64'(bus32.hi), 64'h1234);
        check_output("flush_lo", 64'(bus32.lo), 64'h5678);

        // flush beats start in IDLE; op 110 is a no-op
        bus32.flush = 1'b1;
        apply_stimulus(1'b0, 3'b000, 32'd3, 32'd4);
        bus32.flush = 1'b0;
        check_output("idle_flush_busy", 64'(bus32.busy), 64'd0);
        apply_stimulus(1'b0, 3'b110, 32'hDEAD_BEEF, 32'd1);
        check_output("nop_busy", 64'(bus32.busy), 64'd0);
        check_output("nop_hi", 64'(bus32.hi), 64'h1234);
        check_output("nop_lo", 64'(bus32.lo), 64'h5678);

        $display("[TB] WIDTH=8 MULT and async reset mid-CALC");
        apply_stimulus(1'b1, 3'b001, 32'h80, 32'h80);
        wait_done(1'b1, lat, busy_cnt);
        check_output("w8_lat", 64'(lat), 64'd9);
        check_output("w8_hi", 64'(bus8.hi), 64'h40);
        check_output("w8_lo", 64'(bus8.lo), 64'h00);
        tick();
        apply_stimulus(1'b1, 3'b000, 32'h0F, 32'h0F);
        tick();
        tick();
        check_output("w8_mid_busy", 64'(bus8.busy), 64'd1);
        #3;
        rst = 1'b1;
        #1;
        check_output("w8_rst_busy", 64'(bus8.busy), 64'd0);
        check_output("w8_rst_done", 64'(bus8.done), 64'd0);
        check_output("w8_rst_hi", 64'(bus8.hi), 64'd0);
        check_output("w8_rst_lo", 64'(bus8.lo), 64'd0);
        check_output("w32_rst_hi", 64'(bus32.hi), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        check_output("w8_post_rst_busy", 64'(bus8.busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
